// File: rtl/scan_programmer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_programmer_pkg
// Description : Shared types and constants for the scan-chain programmer.
//               It holds the controller state encoding, the byte width and the
//               default scan-chain length of the attached microcontroller.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_programmer_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEF_CHAIN_LEN = 280;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DUMP = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/scan_byte_shifter.sv
`default_nettype none
// ============================================================================
// Module      : scan_byte_shifter
// Description : One-byte scan engine. It shifts a parallel byte out LSB first
//               on o_scan_in, and at the same time captures i_scan_out LSB
//               first. In rotate mode the chain tail is fed straight back to
//               the chain head, so the chain contents are preserved.
// Ports       : clk, rst (async, active low)
//               i_abort    - drop any shift in progress
//               i_start    - begin an 8-cycle shift (ignored while busy)
//               i_rotate   - shift mode for this byte: 1 = recirculate tail
//               i_data     - byte to serialise
//               i_scan_out - chain tail
//               o_busy     - shift in progress (drives scan_enable)
//               o_complete - last shift cycle; o_capture is valid
//               o_scan_in  - chain head
//               o_capture  - captured byte including the bit sampled this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module scan_byte_shifter
    import scan_programmer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_abort,
    input  logic              i_start,
    input  logic              i_rotate,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_scan_out,
    output logic              o_busy,
    output logic              o_complete,
    output logic              o_scan_in,
    output logic [BYTE_W-1:0] o_capture
);

    localparam logic [2:0] C_LAST_BIT = 3'(BYTE_W - 1);

    logic              r_busy;
    logic              r_rotate;
    logic [2:0]        r_bit_cnt;
    logic [BYTE_W-1:0] r_piso;
    logic [BYTE_W-1:0] r_sipo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy    <= 1'b0;
            r_rotate  <= 1'b0;
            r_bit_cnt <= 3'd0;
            r_piso    <= '0;
            r_sipo    <= '0;
        end else if (i_abort) begin
            r_busy    <= 1'b0;
            r_bit_cnt <= 3'd0;
        end else if (r_busy) begin
            r_piso    <= {1'b0, r_piso[BYTE_W-1:1]};
            r_sipo    <= {i_scan_out, r_sipo[BYTE_W-1:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == C_LAST_BIT) begin
                r_busy <= 1'b0;
            end
        end else if (i_start) begin
            r_busy    <= 1'b1;
            r_rotate  <= i_rotate;
            r_piso    <= i_data;
            r_bit_cnt <= 3'd0;
        end
    end

    assign o_busy     = r_busy;
    assign o_complete = r_busy && (r_bit_cnt == C_LAST_BIT);
    // Gated by busy so the chain head idles low outside a shift.
    assign o_scan_in  = r_busy && (r_rotate ? i_scan_out : r_piso[0]);
    // The final bit is still on the wire during the completing cycle.
    assign o_capture  = {i_scan_out, r_sipo[BYTE_W-1:1]};

endmodule
`default_nettype wire

// File: rtl/scan_programmer.sv
`default_nettype none
// ============================================================================
// Module      : scan_programmer
// Description : Byte-wide load/run/dump engine for a microcontroller scan
//               chain. LOAD shifts CHAIN_LEN/8 host bytes in and returns the
//               displaced bytes. RUN enables the processor until halt. DUMP
//               rotates the chain once and returns its contents unchanged.
// Ports       : clk, rst (async, active low)
//               load_start, dump_start, abort - control pulses
//               in_data/in_valid/in_ready     - host load stream
//               out_data/out_valid/out_ready  - captured byte stream
//               scan_enable, scan_in, scan_out, proc_en, halt - to/from MCU
//               busy, done                    - status
// Revision    : 1.0 - initial release
// ============================================================================
module scan_programmer
    import scan_programmer_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              dump_start,
    input  logic              abort,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              scan_enable,
    output logic              scan_in,
    input  logic              scan_out,
    output logic              proc_en,
    input  logic              halt,
    output logic              busy,
    output logic              done
);

    localparam int              NBYTES = CHAIN_LEN / BYTE_W;
    localparam int              BC_W   = $clog2(NBYTES + 1);
    localparam logic [BC_W-1:0] C_LAST = BC_W'(NBYTES);

    state_t            r_state;
    logic [BC_W-1:0]   r_byte_cnt;
    logic [BYTE_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_proc_en;
    logic              r_done;

    logic              w_sh_busy;
    logic              w_complete;
    logic [BYTE_W-1:0] w_capture;
    logic              w_in_ready;
    logic              w_out_take;
    logic              w_last;
    logic              w_start;
    logic              w_rotate;

    assign w_in_ready = (r_state == ST_LOAD) && !w_sh_busy && !r_out_valid;
    assign w_out_take = r_out_valid && out_ready;
    assign w_last     = (r_byte_cnt == C_LAST);
    assign w_rotate   = (r_state != ST_LOAD);

    // The first dump byte is launched on the same edge that leaves RUN or
    // IDLE, so scan_enable rises together with the DUMP state.
    assign w_start = ((r_state == ST_LOAD) && in_valid && w_in_ready)
                  || ((r_state == ST_RUN) && halt)
                  || ((r_state == ST_IDLE) && !load_start && dump_start)
                  || ((r_state == ST_DUMP) && !w_sh_busy && !r_out_valid && !w_last);

    scan_byte_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .i_abort    (abort),
        .i_start    (w_start),
        .i_rotate   (w_rotate),
        .i_data     (in_data),
        .i_scan_out (scan_out),
        .o_busy     (w_sh_busy),
        .o_complete (w_complete),
        .o_scan_in  (scan_in),
        .o_capture  (w_capture)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_byte_cnt  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_proc_en   <= 1'b0;
            r_done      <= 1'b0;
        end else if (abort) begin
            r_state     <= ST_IDLE;
            r_byte_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_proc_en   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // byte counter counts completed shifts within the current state
            if (w_complete) begin
                r_out_data  <= w_capture;
                r_out_valid <= 1'b1;
                r_byte_cnt  <= r_byte_cnt + BC_W'(1);
            end else if (w_out_take) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (load_start) begin
                        r_state    <= ST_LOAD;
                        r_byte_cnt <= '0;
                    end else if (dump_start) begin
                        r_state    <= ST_DUMP;
                        r_byte_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_out_take && w_last) begin
                        r_state    <= ST_RUN;
                        r_proc_en  <= 1'b1;
                        r_byte_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        r_state    <= ST_DUMP;
                        r_proc_en  <= 1'b0;
                        r_byte_cnt <= '0;
                    end
                end
                ST_DUMP: begin
                    if (w_out_take && w_last) begin
                        r_state    <= ST_IDLE;
                        r_done     <= 1'b1;
                        r_byte_cnt <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign scan_enable = w_sh_busy;
    assign proc_en     = r_proc_en;
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_scan_programmer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_programmer
// Description : Self-checking bench for scan_programmer with a 16-bit chain
//               model. Expected bytes come from a transaction-level model of
//               the chain contents held as a plain 16-bit value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_programmer;

    localparam int CL = 16;
    localparam int NB = CL / 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_start = 1'b0;
    logic       dump_start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       scan_enable;
    logic       scan_in;
    logic       scan_out;
    logic       proc_en;
    logic       halt = 1'b0;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    scan_programmer #(.CHAIN_LEN(CL)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .dump_start  (dump_start),
        .abort       (abort),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .scan_enable (scan_enable),
        .scan_in     (scan_in),
        .scan_out    (scan_out),
        .proc_en     (proc_en),
        .halt        (halt),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Microcontroller chain: head enters at the top, tail leaves at bit 0.
    logic [CL-1:0] chain = '0;
    logic          chain_clr = 1'b0;
    always @(posedge clk) begin
        if (chain_clr)        chain <= '0;
        else if (scan_enable) chain <= {scan_in, chain[CL-1:1]};
    end
    assign scan_out = chain[0];

    logic si_q[$];
    bit   se_log_en = 1'b0;
    int   done_cnt = 0;
    int   overlap_cnt = 0;
    always @(posedge clk) begin
        if (se_log_en && scan_enable) si_q.push_back(scan_in);
        if (done) done_cnt++;
        if (scan_enable && proc_en) overlap_cnt++;
    end

    // Reference model: chain contents as one value, byte 0 at the tail.
    logic [CL-1:0] exp_chain = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeout("in_ready_wait");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv_byte(input logic [7:0] exp, input string tag, input bit rnd);
        int n;
        n = 0;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!(out_valid && out_ready) && n < 400) begin
            @(negedge clk);
            n++;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        if (!(out_valid && out_ready)) timeout({tag, "_wait"});
        else chk(tag, out_data, exp);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_halt(input int hd);
        int n, pc;
        n = 0;
        pc = 0;
        while (!proc_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!proc_en) timeout("proc_en_wait");
        repeat (hd - 1) begin
            if (proc_en) pc++;
            @(negedge clk);
        end
        if (proc_en) pc++;
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("proc_en_cycles", pc, hd);
        chk("halt_to_dump", {proc_en, scan_enable, busy}, 3'b011);
    endtask

    task automatic dump_phase(input bit rnd, input string tag);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < NB; i++) recv_byte(exp_chain[i*8 +: 8], {tag, "_byte"}, rnd);
        chk({tag, "_done"}, {done, busy}, 2'b10);
        @(negedge clk);
        chk({tag, "_done_once"}, done_cnt - d0, 1);
        chk({tag, "_chain"}, chain, exp_chain);
    endtask

    task automatic do_load(input logic [7:0] b0, input logic [7:0] b1,
                           input bit rnd, input int hd, input bit do_start);
        logic [CL-1:0] old;
        old = exp_chain;
        if (do_start) begin
            load_start = 1'b1;
            @(negedge clk);
            load_start = 1'b0;
        end
        send_byte(b0);
        recv_byte(old[7:0], "load_out0", rnd);
        send_byte(b1);
        recv_byte(old[15:8], "load_out1", rnd);
        exp_chain = {b1, b0};
        chk("run_entry", {proc_en, scan_enable}, 2'b10);
        chk("load_chain", chain, exp_chain);
        run_halt(hd);
        dump_phase(rnd, "dump");
    endtask

    task automatic dump_only(input bit rnd);
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        dump_phase(rnd, "dumponly");
    endtask

    initial begin
        int hi, st, d0;
        logic [15:0] seq;

        // reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy, in_ready, out_valid, scan_enable, scan_in, proc_en, done, out_data}, 0);
        rst = 1'b1;
        @(negedge clk);

        // reset asserted in the middle of a load byte
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        send_byte(8'h5A);
        repeat (2) @(negedge clk);
        chk("midload_shifting", scan_enable, 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_load", {busy, in_ready, out_valid, scan_enable, scan_in, proc_en, done, out_data}, 0);
        @(negedge clk);
        rst = 1'b1;
        chain_clr = 1'b1;
        @(negedge clk);
        chain_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_rst", {busy, in_ready, scan_enable}, 0);
        exp_chain = '0;

        // directed load of A5, 3C with timing and back-pressure checks
        si_q.delete();
        se_log_en = 1'b1;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("load_in_ready", in_ready, 1);
        in_data  = 8'hA5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        hi = 0;
        repeat (8) begin
            if (scan_enable && !out_valid && !in_ready) hi++;
            @(negedge clk);
        end
        chk("shift_window", hi, 8);
        chk("out_at_t9", {scan_enable, out_valid}, 2'b01);
        chk("out_byte0", out_data, exp_chain[7:0]);
        st = 0;
        repeat (20) begin
            @(negedge clk);
            if (!in_ready && !scan_enable && out_valid && out_data === exp_chain[7:0]) st++;
        end
        chk("stall_hold", st, 20);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("resume_in_ready", {in_ready, out_valid}, 2'b10);
        send_byte(8'h3C);
        recv_byte(exp_chain[15:8], "out_byte1", 1'b0);
        se_log_en = 1'b0;
        exp_chain = {8'h3C, 8'hA5};
        chk("scan_in_count", si_q.size(), 16);
        seq = '0;
        for (int i = 0; i < 16 && i < si_q.size(); i++) seq[i] = si_q[i];
        chk("scan_in_seq", seq, exp_chain);
        chk("run_entry0", {proc_en, scan_enable}, 2'b10);
        run_halt(5);
        dump_phase(1'b0, "dump0");

        // second load returns the first program
        do_load(8'h11, 8'h22, 1'b1, 3, 1'b1);

        // abort after three shift cycles
        d0 = done_cnt;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        send_byte(8'h77);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {scan_enable, busy, out_valid, done, proc_en}, 0);
        @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chain_clr = 1'b1;
        @(negedge clk);
        chain_clr = 1'b0;
        exp_chain = '0;

        // simultaneous starts: load wins, later dump_start ignored
        load_start = 1'b1;
        dump_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        dump_start = 1'b0;
        chk("both_start_load", {in_ready, busy, scan_enable}, 3'b110);
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        @(negedge clk);
        chk("dump_in_load_ignored", {in_ready, scan_enable}, 2'b10);
        do_load(8'hC3, 8'h96, 1'b0, 2, 1'b0);

        // randomized sequences
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            if ($urandom_range(0, 2) == 0) dump_only(1'b1);
            else do_load(8'($urandom), 8'($urandom), 1'b1, $urandom_range(1, 8), 1'b1);
        end

        chk("no_scan_proc_overlap", overlap_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
